// File: rtl/hub75_scan_driver_if.sv
// Renderer query port and HUB75 panel pins for the scan driver.
// master = scan driver, slave = renderer/panel side.
interface hub75_scan_driver_if;
    logic [5:0] qx;
    logic [4:0] qy;
    logic       pix_top;
    logic       pix_bot;
    logic       hub_r1;
    logic       hub_r2;
    logic       hub_clk;
    logic       hub_lat;
    logic       hub_oe_n;
    logic [4:0] hub_addr;
    logic       frame_done;

    modport master (
        output qx, qy,
        input  pix_top, pix_bot,
        output hub_r1, hub_r2, hub_clk, hub_lat, hub_oe_n, hub_addr, frame_done
    );

    modport slave (
        input  qx, qy,
        output pix_top, pix_bot,
        input  hub_r1, hub_r2, hub_clk, hub_lat, hub_oe_n, hub_addr, frame_done
    );
endinterface

// File: rtl/hub75_scan_driver.sv
// 64x64 single-colour HUB75 scan driver, 1/32 scan: shift a row pair, latch it,
// then light it for ON_CYCLES before moving to the next pair.
module hub75_scan_driver #(
    parameter int CLK_DIV    = 1,
    parameter int LAT_CYCLES = 1,
    parameter int ON_CYCLES  = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    hub75_scan_driver_if.master        bus
);
    localparam int PH_W   = $clog2(2 * CLK_DIV);
    localparam int DW_MAX = (LAT_CYCLES > ON_CYCLES) ? LAT_CYCLES : ON_CYCLES;
    localparam int DW_W   = $clog2(DW_MAX + 1);

    localparam logic [PH_W-1:0] PH_RISE  = PH_W'(CLK_DIV);
    localparam logic [PH_W-1:0] PH_LAST  = PH_W'(2 * CLK_DIV - 1);
    localparam logic [DW_W-1:0] LAT_LAST = DW_W'(LAT_CYCLES - 1);
    localparam logic [DW_W-1:0] ON_LAST  = DW_W'(ON_CYCLES - 1);

    typedef enum logic [1:0] {SHIFT, LATCH, DISPLAY} state_t;

    state_t          state_q, state_d;
    logic [5:0]      col_q, col_d;
    logic [4:0]      row_q, row_d;
    logic [PH_W-1:0] phase_q, phase_d;
    logic [DW_W-1:0] dwell_q, dwell_d;

    logic       hub_r1_q, hub_r1_d;
    logic       hub_r2_q, hub_r2_d;
    logic       hub_clk_q, hub_clk_d;
    logic       hub_lat_q, hub_lat_d;
    logic       hub_oe_n_q, hub_oe_n_d;
    logic [4:0] hub_addr_q, hub_addr_d;
    logic       frame_done_q, frame_done_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= SHIFT;
            col_q        <= '0;
            row_q        <= '0;
            phase_q      <= '0;
            dwell_q      <= '0;
            hub_r1_q     <= 1'b0;
            hub_r2_q     <= 1'b0;
            hub_clk_q    <= 1'b0;
            hub_lat_q    <= 1'b0;
            hub_oe_n_q   <= 1'b1;
            hub_addr_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            phase_q      <= phase_d;
            dwell_q      <= dwell_d;
            hub_r1_q     <= hub_r1_d;
            hub_r2_q     <= hub_r2_d;
            hub_clk_q    <= hub_clk_d;
            hub_lat_q    <= hub_lat_d;
            hub_oe_n_q   <= hub_oe_n_d;
            hub_addr_q   <= hub_addr_d;
            frame_done_q <= frame_done_d;
        end
    end

    // lat/oe_n are decoded from the current state, so they stay asserted for
    // exactly the number of cycles spent in LATCH/DISPLAY, one cycle later.
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        phase_d      = phase_q;
        dwell_d      = dwell_q;
        hub_r1_d     = hub_r1_q;
        hub_r2_d     = hub_r2_q;
        hub_clk_d    = hub_clk_q;
        hub_lat_d    = 1'b0;
        hub_oe_n_d   = 1'b1;
        hub_addr_d   = hub_addr_q;
        frame_done_d = 1'b0;

        case (state_q)
            SHIFT: begin
                if (phase_q == '0) begin
                    hub_r1_d  = bus.pix_top;
                    hub_r2_d  = bus.pix_bot;
                    hub_clk_d = 1'b0;
                end
                if (phase_q == PH_RISE) begin
                    hub_clk_d = 1'b1;
                end
                if (phase_q == PH_LAST) begin
                    phase_d = '0;
                    col_d   = col_q + 6'd1;
                    if (col_q == 6'd63) begin
                        state_d = LATCH;
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end

            // Address moves only here, while the panel is blanked.
            LATCH: begin
                hub_lat_d  = 1'b1;
                hub_addr_d = row_q;
                hub_clk_d  = 1'b0;
                if (dwell_q == LAT_LAST) begin
                    dwell_d = '0;
                    state_d = DISPLAY;
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end

            DISPLAY: begin
                hub_oe_n_d = 1'b0;
                if (dwell_q == ON_LAST) begin
                    dwell_d      = '0;
                    row_d        = row_q + 5'd1;
                    state_d      = SHIFT;
                    frame_done_d = (row_q == 5'd31);
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end

            default: begin
                state_d = SHIFT;
            end
        endcase
    end

    assign bus.qx         = col_q;
    assign bus.qy         = row_q;
    assign bus.hub_r1     = hub_r1_q;
    assign bus.hub_r2     = hub_r2_q;
    assign bus.hub_clk    = hub_clk_q;
    assign bus.hub_lat    = hub_lat_q;
    assign bus.hub_oe_n   = hub_oe_n_q;
    assign bus.hub_addr   = hub_addr_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_hub75_scan_driver.sv
// Directed bench: default-parameter driver with stub/ball renderers, plus a
// second instance with CLK_DIV=3, LAT_CYCLES=2, ON_CYCLES=10.
module tb_hub75_scan_driver;
    localparam int ROW_A = 128 * 1 + 1 + 64;
    localparam int ROW_B = 128 * 3 + 2 + 10;
    localparam logic [5:0] BALL_X = 6'd10;
    localparam logic [5:0] BALL_Y = 6'd40;
    localparam logic [63:0] ALT_TOP = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [63:0] ALT_BOT = 64'h5555_5555_5555_5555;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    logic [1:0] mode_a = 2'd0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hub75_scan_driver_if a_if ();
    hub75_scan_driver_if b_if ();

    hub75_scan_driver dut_a (.clk(clk), .rst(rst_a), .bus(a_if));

    hub75_scan_driver #(.CLK_DIV(3), .LAT_CYCLES(2), .ON_CYCLES(10)) dut_b (
        .clk(clk), .rst(rst_b), .bus(b_if));

    // Renderer stubs: 0 = alternating columns, 1 = single ball pixel, 2 = all on
    logic ball_top, ball_bot;
    assign ball_top = (a_if.qx == BALL_X) && ({1'b0, a_if.qy} == BALL_Y);
    assign ball_bot = (a_if.qx == BALL_X) && ({1'b1, a_if.qy} == BALL_Y);
    assign a_if.pix_top = (mode_a == 2'd0) ? a_if.qx[0] : (mode_a == 2'd1) ? ball_top : 1'b1;
    assign a_if.pix_bot = (mode_a == 2'd0) ? ~a_if.qx[0] : (mode_a == 2'd1) ? ball_bot : 1'b1;
    assign b_if.pix_top = b_if.qx[0];
    assign b_if.pix_bot = ~b_if.qx[0];

    // Per-row observations of dut_a
    logic [63:0] cap_r1 [0:32];
    logic [63:0] cap_r2 [0:32];
    int          edges [0:32];
    int          latc [0:32];
    int          oec [0:32];
    logic [4:0]  addr_at_lat [0:32];
    int          fd_cnt, fd_first, fd_wide, oe_addr_chg;
    logic [4:0]  qy_at_fd, addr_at_fd;

    task automatic reset_a();
        rst_a = 1'b1;
        repeat (3) @(negedge clk);
        rst_a = 1'b0;
    endtask

    // Sample k (k>=1) sees the outputs registered on the k-th edge after release.
    task automatic capture_a(input int nrows);
        logic pclk, plat, pfd;
        logic [4:0] paddr;
        int rr, e;
        for (int r = 0; r < 33; r++) begin
            cap_r1[r] = '0; cap_r2[r] = '0;
            edges[r] = 0; latc[r] = 0; oec[r] = 0; addr_at_lat[r] = 5'h1f;
        end
        fd_cnt = 0; fd_first = -1; fd_wide = 0; oe_addr_chg = 0;
        qy_at_fd = 5'h1f; addr_at_fd = 5'h00;
        pclk = 1'b0; plat = 1'b0; pfd = 1'b0; paddr = a_if.hub_addr;
        for (int k = 1; k <= nrows * ROW_A; k++) begin
            @(negedge clk);
            rr = (k - 1) / ROW_A;
            if (!pclk && a_if.hub_clk) begin
                e = edges[rr];
                if (e < 64) begin
                    cap_r1[rr][e[5:0]] = a_if.hub_r1;
                    cap_r2[rr][e[5:0]] = a_if.hub_r2;
                end
                edges[rr]++;
            end
            if (a_if.hub_lat) begin
                latc[rr]++;
                if (!plat) addr_at_lat[rr] = a_if.hub_addr;
            end
            if (!a_if.hub_oe_n) begin
                oec[rr]++;
                if (a_if.hub_addr !== paddr) oe_addr_chg++;
            end
            if (a_if.frame_done) begin
                fd_cnt++;
                if (pfd) fd_wide++;
                if (fd_first < 0) begin
                    fd_first = k;
                    qy_at_fd = a_if.qy;
                    addr_at_fd = a_if.hub_addr;
                end
            end
            pclk = a_if.hub_clk; plat = a_if.hub_lat; pfd = a_if.frame_done;
            paddr = a_if.hub_addr;
        end
    endtask

    task automatic test_reset();
        mode_a = 2'd2;
        rst_a = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (a_if.hub_oe_n !== 1'b1) begin errors++; $display("FAIL reset_oe_n: got %b expected 1", a_if.hub_oe_n); end
        checks++; if (a_if.hub_r1 !== 1'b0) begin errors++; $display("FAIL reset_r1: got %b expected 0", a_if.hub_r1); end
        checks++; if (a_if.hub_r2 !== 1'b0) begin errors++; $display("FAIL reset_r2: got %b expected 0", a_if.hub_r2); end
        checks++; if (a_if.hub_clk !== 1'b0) begin errors++; $display("FAIL reset_clk: got %b expected 0", a_if.hub_clk); end
        checks++; if (a_if.hub_lat !== 1'b0) begin errors++; $display("FAIL reset_lat: got %b expected 0", a_if.hub_lat); end
        checks++; if (a_if.hub_addr !== 5'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", a_if.hub_addr); end
        checks++; if (a_if.frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", a_if.frame_done); end
        checks++; if (a_if.qx !== 6'd0 || a_if.qy !== 5'd0) begin errors++; $display("FAIL reset_query: got qx=%0d qy=%0d expected 0 0", a_if.qx, a_if.qy); end
        checks++; if (b_if.hub_oe_n !== 1'b1 || b_if.hub_clk !== 1'b0) begin errors++; $display("FAIL reset_b: got oe_n=%b clk=%b expected 1 0", b_if.hub_oe_n, b_if.hub_clk); end
    endtask

    task automatic test_shift_pattern();
        mode_a = 2'd0;
        reset_a();
        capture_a(33);
        for (int r = 0; r < 33; r++) begin
            checks++; if (edges[r] != 64) begin errors++; $display("FAIL shift_edges row%0d: got %0d expected 64", r, edges[r]); end
            checks++; if (cap_r1[r] !== ALT_TOP) begin errors++; $display("FAIL shift_r1 row%0d: got %h expected %h", r, cap_r1[r], ALT_TOP); end
            checks++; if (cap_r2[r] !== ALT_BOT) begin errors++; $display("FAIL shift_r2 row%0d: got %h expected %h", r, cap_r2[r], ALT_BOT); end
        end
    endtask

    task automatic test_latch_addr();
        for (int r = 0; r < 33; r++) begin
            checks++; if (latc[r] != 1) begin errors++; $display("FAIL lat_width row%0d: got %0d expected 1", r, latc[r]); end
            checks++; if (addr_at_lat[r] !== 5'(r % 32)) begin errors++; $display("FAIL addr row%0d: got %0d expected %0d", r, addr_at_lat[r], r % 32); end
        end
        checks++; if (oe_addr_chg != 0) begin errors++; $display("FAIL addr_stable_oe: got %0d changes expected 0", oe_addr_chg); end
    endtask

    task automatic test_frame();
        for (int r = 0; r < 33; r++) begin
            checks++; if (oec[r] != 64) begin errors++; $display("FAIL on_time row%0d: got %0d expected 64", r, oec[r]); end
        end
        checks++; if (fd_first != 6176) begin errors++; $display("FAIL frame_done_time: got %0d expected 6176", fd_first); end
        checks++; if (fd_cnt != 1) begin errors++; $display("FAIL frame_done_count: got %0d expected 1", fd_cnt); end
        checks++; if (fd_wide != 0) begin errors++; $display("FAIL frame_done_width: got %0d extra cycles expected 0", fd_wide); end
        checks++; if (qy_at_fd !== 5'd0) begin errors++; $display("FAIL frame_done_wrap_qy: got %0d expected 0", qy_at_fd); end
        checks++; if (addr_at_fd !== 5'd31) begin errors++; $display("FAIL frame_done_addr: got %0d expected 31", addr_at_fd); end
    endtask

    task automatic test_reset_mid_display();
        mode_a = 2'd0;
        reset_a();
        repeat (5 * ROW_A + 150) @(negedge clk);
        checks++; if (a_if.hub_oe_n !== 1'b0) begin errors++; $display("FAIL middisp_pre_oe_n: got %b expected 0", a_if.hub_oe_n); end
        checks++; if (a_if.hub_addr !== 5'd5) begin errors++; $display("FAIL middisp_pre_addr: got %0d expected 5", a_if.hub_addr); end
        #1 rst_a = 1'b1;
        #1;
        checks++; if (a_if.hub_oe_n !== 1'b1) begin errors++; $display("FAIL middisp_async_oe_n: got %b expected 1", a_if.hub_oe_n); end
        checks++; if (a_if.hub_addr !== 5'd0 || a_if.qy !== 5'd0) begin errors++; $display("FAIL middisp_async_addr: got addr=%0d qy=%0d expected 0 0", a_if.hub_addr, a_if.qy); end
        @(negedge clk);
        rst_a = 1'b0;
        capture_a(1);
        checks++; if (addr_at_lat[0] !== 5'd0) begin errors++; $display("FAIL middisp_restart_addr: got %0d expected 0", addr_at_lat[0]); end
        checks++; if (edges[0] != 64 || cap_r1[0] !== ALT_TOP) begin errors++; $display("FAIL middisp_restart_shift: got edges=%0d r1=%h expected 64 %h", edges[0], cap_r1[0], ALT_TOP); end
    endtask

    task automatic test_param_sweep();
        int prise, first_rise, rises0, bad_period, bad_high, bad_data, hi_run;
        int latc0, oec0, lat_k0, lat_k1;
        logic pclk, plat, exp_bit;
        prise = -1; first_rise = -1; rises0 = 0; bad_period = 0; bad_high = 0;
        bad_data = 0; hi_run = 0; latc0 = 0; oec0 = 0; lat_k0 = -1; lat_k1 = -1;
        pclk = 1'b0; plat = 1'b0;
        rst_b = 1'b1;
        repeat (2) @(negedge clk);
        rst_b = 1'b0;
        for (int k = 1; k <= 2 * ROW_B; k++) begin
            @(negedge clk);
            if (!pclk && b_if.hub_clk) begin
                if (first_rise < 0) first_rise = k;
                if (k <= ROW_B) begin
                    exp_bit = rises0[0];
                    if (b_if.hub_r1 !== exp_bit || b_if.hub_r2 !== ~exp_bit) bad_data++;
                    if (prise >= 0 && k - prise != 6) bad_period++;
                    rises0++;
                    prise = k;
                end
            end
            if (b_if.hub_clk) hi_run++;
            else begin
                if (pclk && hi_run != 3) bad_high++;
                hi_run = 0;
            end
            if (b_if.hub_lat && !plat) begin
                if (k <= ROW_B) lat_k0 = k; else lat_k1 = k;
            end
            if (k <= ROW_B) begin
                if (b_if.hub_lat) latc0++;
                if (!b_if.hub_oe_n) oec0++;
            end
            pclk = b_if.hub_clk; plat = b_if.hub_lat;
        end
        checks++; if (first_rise != 4) begin errors++; $display("FAIL sweep_first_rise: got %0d expected 4", first_rise); end
        checks++; if (rises0 != 64) begin errors++; $display("FAIL sweep_edges: got %0d expected 64", rises0); end
        checks++; if (bad_period != 0) begin errors++; $display("FAIL sweep_clk_period: got %0d bad expected 0", bad_period); end
        checks++; if (bad_high != 0) begin errors++; $display("FAIL sweep_clk_high: got %0d bad expected 0", bad_high); end
        checks++; if (bad_data != 0) begin errors++; $display("FAIL sweep_data: got %0d bad expected 0", bad_data); end
        checks++; if (latc0 != 2) begin errors++; $display("FAIL sweep_lat_width: got %0d expected 2", latc0); end
        checks++; if (oec0 != 10) begin errors++; $display("FAIL sweep_on_time: got %0d expected 10", oec0); end
        checks++; if (lat_k0 != 385) begin errors++; $display("FAIL sweep_lat_time: got %0d expected 385", lat_k0); end
        checks++; if (lat_k1 - lat_k0 != 396) begin errors++; $display("FAIL sweep_row_period: got %0d expected 396", lat_k1 - lat_k0); end
    endtask

    task automatic test_scoreboard();
        logic [63:0] exp_r2;
        mode_a = 2'd1;
        reset_a();
        capture_a(32);
        for (int r = 0; r < 32; r++) begin
            exp_r2 = '0;
            for (int c = 0; c < 64; c++)
                exp_r2[c] = (6'(c) == BALL_X) && (6'(r + 32) == BALL_Y);
            checks++; if (cap_r2[r] !== exp_r2) begin errors++; $display("FAIL ball_r2 row%0d: got %h expected %h", r, cap_r2[r], exp_r2); end
            checks++; if (cap_r1[r] !== 64'd0) begin errors++; $display("FAIL ball_r1 row%0d: got %h expected 0", r, cap_r1[r]); end
        end
        checks++; if (cap_r2[8][10] !== 1'b1) begin errors++; $display("FAIL ball_hit: got %b expected 1", cap_r2[8][10]); end
    endtask

    initial begin
        test_reset();
        test_shift_pattern();
        test_latch_addr();
        test_frame();
        test_reset_mid_display();
        test_param_sweep();
        test_scoreboard();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
